// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use / RAW hazard detection and operand selection.
// Build option: define FORWARD_EN to enable the EX/MEM and MEM/WB operand bypass network.
module id_ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [31:0] id_rd1,
    input  logic [31:0] id_rd2,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_dst,
    input  logic [4:0]  id_alu_control,
    input  logic        id_alu_src,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        id_mem_write,
    input  logic        flush,
    input  logic        mem_reg_write,
    input  logic [4:0]  mem_dst,
    input  logic [31:0] mem_result,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_dst,
    input  logic [31:0] wb_result,
    output logic [31:0] src_a,
    output logic [31:0] src_b,
    output logic [4:0]  ex_alu_control,
    output logic        ex_valid,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic [4:0]  ex_dst,
    output logic [31:0] ex_store_data,
    output logic        stall_id
);

    localparam logic [4:0] ALU_ADD = 5'd0;

    logic        r_valid;
    logic        r_reg_write;
    logic        r_mem_read;
    logic        r_mem_write;
    logic [4:0]  r_dst;
    logic [4:0]  r_alu_control;
    logic        r_alu_src;
    logic [31:0] r_rd1;
    logic [31:0] r_rd2;
    logic [31:0] r_imm;
    logic [4:0]  r_rs;
    logic [4:0]  r_rt;

    logic        w_bubble;
    logic        w_stall;
    logic        w_ex_hit;
    logic [31:0] w_opa;
    logic [31:0] w_opb;

    // Register 0 is hardwired, so it never creates a dependency.
    assign w_ex_hit = (r_dst != 5'd0) && ((r_dst == id_rs) || (r_dst == id_rt));

`ifdef FORWARD_EN
    // Only a load in EX cannot be bypassed in time; everything else forwards.
    assign w_stall = id_valid && r_valid && r_mem_read && w_ex_hit;

    // EX/MEM result is younger than MEM/WB, so it wins.
    assign w_opa = (mem_reg_write && mem_dst == r_rs && r_rs != 5'd0) ? mem_result :
                   (wb_reg_write  && wb_dst  == r_rs && r_rs != 5'd0) ? wb_result  : r_rd1;
    assign w_opb = (mem_reg_write && mem_dst == r_rt && r_rt != 5'd0) ? mem_result :
                   (wb_reg_write  && wb_dst  == r_rt && r_rt != 5'd0) ? wb_result  : r_rd2;
`else
    logic w_mem_hit;
    logic w_unused;

    assign w_mem_hit = (mem_dst != 5'd0) && ((mem_dst == id_rs) || (mem_dst == id_rt));
    // WB writers need no stall: the register file writes before it reads.
    assign w_stall   = id_valid && ((r_valid && r_reg_write && w_ex_hit) ||
                                    (mem_reg_write && w_mem_hit));
    assign w_opa     = r_rd1;
    assign w_opb     = r_rd2;
    assign w_unused  = ^{mem_result, wb_reg_write, wb_dst, wb_result, r_rs, r_rt};
`endif

    assign stall_id = w_stall;
    assign w_bubble = flush || w_stall || !id_valid;

    // NOTE: reset is synchronous and shares the bubble path, so it overrides flush,
    // stall and all id_* inputs; state updates use non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset || w_bubble) begin
            r_valid       <= 1'b0;
            r_reg_write   <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_dst         <= 5'd0;
            r_alu_control <= ALU_ADD;
            r_alu_src     <= 1'b0;
            r_rd1         <= 32'd0;
            r_rd2         <= 32'd0;
            r_imm         <= 32'd0;
            r_rs          <= 5'd0;
            r_rt          <= 5'd0;
        end else begin
            r_valid       <= 1'b1;
            r_reg_write   <= id_reg_write;
            r_mem_read    <= id_mem_read;
            r_mem_write   <= id_mem_write;
            r_dst         <= id_dst;
            r_alu_control <= id_alu_control;
            r_alu_src     <= id_alu_src;
            r_rd1         <= id_rd1;
            r_rd2         <= id_rd2;
            r_imm         <= id_imm;
            r_rs          <= id_rs;
            r_rt          <= id_rt;
        end
    end

    assign src_a          = w_opa;
    assign src_b          = r_alu_src ? r_imm : w_opb;
    assign ex_store_data  = w_opb;
    assign ex_alu_control = r_alu_control;
    assign ex_valid       = r_valid;
    assign ex_reg_write   = r_reg_write;
    assign ex_mem_read    = r_mem_read;
    assign ex_mem_write   = r_mem_write;
    assign ex_dst         = r_dst;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage; expectations are hand-computed and
// selected by FORWARD_EN so the same bench covers both builds.
module tb_id_ex_stage;

`ifdef FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        id_valid = 1'b0;
    logic [31:0] id_rd1 = '0, id_rd2 = '0, id_imm = '0;
    logic [4:0]  id_rs = '0, id_rt = '0, id_dst = '0, id_alu_control = '0;
    logic        id_alu_src = 1'b0, id_reg_write = 1'b0, id_mem_read = 1'b0, id_mem_write = 1'b0;
    logic        flush = 1'b0;
    logic        mem_reg_write = 1'b0, wb_reg_write = 1'b0;
    logic [4:0]  mem_dst = '0, wb_dst = '0;
    logic [31:0] mem_result = '0, wb_result = '0;
    logic [31:0] src_a, src_b, ex_store_data;
    logic [4:0]  ex_alu_control, ex_dst;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, stall_id;

    int n_tests = 0;
    int n_fail  = 0;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst),
        .id_alu_control(id_alu_control), .id_alu_src(id_alu_src),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .flush(flush),
        .mem_reg_write(mem_reg_write), .mem_dst(mem_dst), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_dst(wb_dst), .wb_result(wb_result),
        .src_a(src_a), .src_b(src_b), .ex_alu_control(ex_alu_control),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_dst(ex_dst), .ex_store_data(ex_store_data),
        .stall_id(stall_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Outputs are sampled 2 time units after the rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] dst, input logic [31:0] rd1, input logic [31:0] rd2,
                          input logic [31:0] imm, input logic asrc, input logic [4:0] alu,
                          input logic rw, input logic mr, input logic mw);
        id_valid = v; id_rs = rs; id_rt = rt; id_dst = dst;
        id_rd1 = rd1; id_rd2 = rd2; id_imm = imm; id_alu_src = asrc;
        id_alu_control = alu; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
    endtask

    initial begin
        // Reset with a live decode slot.
        set_id(1, 5'd3, 5'd0, 5'd5, 32'd5, 32'd0, 32'd0, 0, 5'd7, 1, 0, 0);
        step();
        reset = 1'b0;
        check("rst_ex_valid", 32'(ex_valid), 32'd0);
        check("rst_src_a", src_a, 32'd0);
        check("rst_src_b", src_b, 32'd0);
        check("rst_store", ex_store_data, 32'd0);
        check("rst_alu", 32'(ex_alu_control), 32'd0);
        check("rst_dst", 32'(ex_dst), 32'd0);
        check("rst_stall", 32'(stall_id), 32'd0);

        // Capture with immediate operand B.
        set_id(1, 5'd3, 5'd5, 5'd10, 32'd7, 32'd9, 32'hFFFF_FFFC, 1, 5'd3, 1, 0, 0);
        #1 check("cap_stall", 32'(stall_id), 32'd0);
        step();
        check("cap_src_a", src_a, 32'd7);
        check("cap_src_b", src_b, 32'hFFFF_FFFC);
        check("cap_store", ex_store_data, 32'd9);
        check("cap_valid", 32'(ex_valid), 32'd1);
        check("cap_dst", 32'(ex_dst), 32'd10);
        check("cap_alu", 32'(ex_alu_control), 32'd3);
        check("cap_rw", 32'(ex_reg_write), 32'd1);

        // ALU writer r10 in EX: stalls only without the bypass network.
        set_id(1, 5'd10, 5'd0, 5'd1, 32'd0, 32'd0, 32'd0, 0, 5'd0, 1, 0, 0);
        #1 check("alu_dep_stall", 32'(stall_id), FWD ? 32'd0 : 32'd1);

        // Flush a valid store.
        set_id(1, 5'd1, 5'd2, 5'd0, 32'h33, 32'h44, 32'd0, 0, 5'd3, 0, 0, 1);
        flush = 1'b1;
        #1 check("flush_stall", 32'(stall_id), 32'd0);
        step();
        flush = 1'b0;
        check("flush_mw", 32'(ex_mem_write), 32'd0);
        check("flush_valid", 32'(ex_valid), 32'd0);
        check("flush_alu", 32'(ex_alu_control), 32'd0);
        check("flush_store", ex_store_data, 32'd0);

        // Store with register operand B.
        set_id(1, 5'd1, 5'd2, 5'd0, 32'h100, 32'h200, 32'h55, 0, 5'd2, 0, 0, 1);
        step();
        check("st_src_a", src_a, 32'h100);
        check("st_src_b", src_b, 32'h200);
        check("st_store", ex_store_data, 32'h200);
        check("st_mw", 32'(ex_mem_write), 32'd1);

        // Invalid decode slot becomes a bubble.
        set_id(0, 5'd1, 5'd2, 5'd4, 32'h100, 32'h200, 32'h55, 0, 5'd2, 1, 0, 1);
        step();
        check("inv_valid", 32'(ex_valid), 32'd0);
        check("inv_src_a", src_a, 32'd0);
        check("inv_mw", 32'(ex_mem_write), 32'd0);

`ifdef FORWARD_EN
        // Bypass priority: EX/MEM over MEM/WB over register file.
        set_id(1, 5'd4, 5'd4, 5'd12, 32'hA, 32'hB, 32'h77, 0, 5'd0, 1, 0, 0);
        step();
        set_id(0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 0, 5'd0, 0, 0, 0);
        mem_reg_write = 1; mem_dst = 5'd4; mem_result = 32'h11;
        wb_reg_write  = 1; wb_dst  = 5'd4; wb_result  = 32'h22;
        #1;
        check("fwd_mem_a", src_a, 32'h11);
        check("fwd_mem_b", src_b, 32'h11);
        check("fwd_mem_st", ex_store_data, 32'h11);
        mem_reg_write = 0;
        #1;
        check("fwd_wb_a", src_a, 32'h22);
        check("fwd_wb_b", src_b, 32'h22);
        wb_reg_write = 0;
        #1;
        check("fwd_none_a", src_a, 32'hA);
        check("fwd_none_b", src_b, 32'hB);
        mem_dst = 5'd0; wb_dst = 5'd0;
`else
        // MEM-stage writer hazard, no bypass.
        set_id(1, 5'd6, 5'd7, 5'd12, 32'h66, 32'h77, 32'd0, 0, 5'd0, 1, 0, 0);
        #1 check("nf_pre_stall", 32'(stall_id), 32'd0);
        step();
        set_id(1, 5'd0, 5'd6, 5'd1, 32'd0, 32'd0, 32'd0, 0, 5'd0, 1, 0, 0);
        mem_reg_write = 1; mem_dst = 5'd6; mem_result = 32'h11;
        #1;
        check("nf_mem_stall", 32'(stall_id), 32'd1);
        check("nf_no_bypass", src_a, 32'h66);
        mem_dst = 5'd0;
        #1 check("nf_mem_r0", 32'(stall_id), 32'd0);
        mem_reg_write = 0; wb_reg_write = 1; wb_dst = 5'd6;
        #1 check("nf_wb_nostall", 32'(stall_id), 32'd0);
        wb_reg_write = 0; wb_dst = 5'd0;
`endif

        // Load to r8 followed by a dependent use: one bubble, then capture.
        set_id(1, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 32'd4, 1, 5'd0, 1, 1, 0);
        step();
        check("ld_mr", 32'(ex_mem_read), 32'd1);
        set_id(1, 5'd8, 5'd0, 5'd9, 32'h80, 32'd0, 32'd0, 0, 5'd1, 1, 0, 0);
        #1 check("lu_stall", 32'(stall_id), 32'd1);
        step();
        check("lu_bubble", 32'(ex_valid), 32'd0);
        check("lu_bubble_rw", 32'(ex_reg_write), 32'd0);
        check("lu_release", 32'(stall_id), 32'd0);
        step();
        check("lu_cap_valid", 32'(ex_valid), 32'd1);
        check("lu_cap_a", src_a, 32'h80);
        check("lu_cap_dst", 32'(ex_dst), 32'd9);

        // rt dependency counts even with an immediate operand; flush+stall is one bubble.
        set_id(1, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 32'd4, 1, 5'd0, 1, 1, 0);
        step();
        set_id(1, 5'd1, 5'd8, 5'd13, 32'd0, 32'd0, 32'd16, 1, 5'd0, 1, 0, 0);
        #1 check("rt_stall", 32'(stall_id), 32'd1);
        flush = 1'b1;
        #1 check("fs_stall", 32'(stall_id), 32'd1);
        step();
        flush = 1'b0;
        check("fs_bubble", 32'(ex_valid), 32'd0);
        #1 check("fs_release", 32'(stall_id), 32'd0);
        step();
        check("fs_cap_valid", 32'(ex_valid), 32'd1);
        check("fs_cap_dst", 32'(ex_dst), 32'd13);

        // Reset during a stall clears it.
        set_id(1, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 32'd4, 1, 5'd0, 1, 1, 0);
        step();
        set_id(1, 5'd8, 5'd0, 5'd9, 32'd0, 32'd0, 32'd0, 0, 5'd0, 1, 0, 0);
        #1 check("rs_stall", 32'(stall_id), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rs_drop", 32'(stall_id), 32'd0);
        check("rs_valid", 32'(ex_valid), 32'd0);
        check("rs_mr", 32'(ex_mem_read), 32'd0);

        // Register 0 is never a hazard or bypass source.
        set_id(1, 5'd0, 5'd0, 5'd0, 32'h5, 32'h6, 32'd0, 0, 5'd0, 1, 1, 0);
        step();
        set_id(1, 5'd0, 5'd0, 5'd2, 32'd0, 32'd0, 32'd0, 0, 5'd0, 1, 0, 0);
        mem_reg_write = 1; mem_dst = 5'd0; mem_result = 32'h99;
        wb_reg_write  = 1; wb_dst  = 5'd0; wb_result  = 32'h98;
        #1;
        check("r0_stall", 32'(stall_id), 32'd0);
        check("r0_src_a", src_a, 32'h5);
        check("r0_store", ex_store_data, 32'h6);
        mem_reg_write = 0; wb_reg_write = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
